// File: rtl/axi_stream_packet_arbiter.sv
// Round-robin, packet-granular merge of NUM_INPUTS AXI-Stream inputs onto one registered output; grant held until TLAST accepted.
// Latency: request to first output beat is 2 cycles; input ready follows !m_tvalid || m_tready, so output stalls stop the granted input.
module axi_stream_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int byte_width = 4,
    parameter int user_width = 1,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_INPUTS-1:0]              s_tvalid,
    output logic [NUM_INPUTS-1:0]              s_tready,
    input  logic [NUM_INPUTS*8*byte_width-1:0] s_tdata,
    input  logic [NUM_INPUTS*byte_width-1:0]   s_tkeep,
    input  logic [NUM_INPUTS-1:0]              s_tlast,
    input  logic [NUM_INPUTS*user_width-1:0]   s_tuser,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [8*byte_width-1:0]            m_tdata,
    output logic [byte_width-1:0]              m_tkeep,
    output logic                               m_tlast,
    output logic [user_width-1:0]              m_tuser,
    output logic [SEL_WIDTH-1:0]               m_tid,
    output logic                               busy,
    output logic [SEL_WIDTH-1:0]               grant_idx
);
    localparam int                   DW       = 8 * byte_width;
    localparam logic [SEL_WIDTH:0]   NUM_W    = (SEL_WIDTH+1)'(NUM_INPUTS);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic {IDLE, PASS} state_t;
    state_t state;

    logic                  sel_vld;
    logic [DW-1:0]         sel_data;
    logic [byte_width-1:0] sel_keep;
    logic                  sel_last;
    logic [user_width-1:0] sel_user;
    logic                  out_free;
    logic                  accept;
    logic [SEL_WIDTH-1:0]  pick_idx;
    logic [SEL_WIDTH:0]    cand;

    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        sel_user = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                sel_vld  = s_tvalid[i];
                sel_data = s_tdata[i*DW +: DW];
                sel_keep = s_tkeep[i*byte_width +: byte_width];
                sel_last = s_tlast[i];
                sel_user = s_tuser[i*user_width +: user_width];
            end
        end
    end

    // Scan from farthest to nearest so the nearest requester after the last grant wins.
    always_comb begin
        pick_idx = grant_idx;
        cand     = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            cand = {1'b0, grant_idx} + (SEL_WIDTH+1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (s_tvalid[cand[SEL_WIDTH-1:0]]) begin
                pick_idx = cand[SEL_WIDTH-1:0];
            end
        end
    end

    assign out_free = !m_tvalid || m_tready;
    assign accept   = (state == PASS) && sel_vld && out_free;

    always_comb begin
        s_tready = '0;
        if (state == PASS && out_free) begin
            s_tready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tlast   <= 1'b0;
            m_tuser   <= '0;
            m_tid     <= '0;
            busy      <= 1'b0;
            grant_idx <= LAST_IDX;
        end else begin
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sel_data;
                m_tkeep  <= sel_keep;
                m_tlast  <= sel_last;
                m_tuser  <= sel_user;
                m_tid    <= grant_idx;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant_idx <= pick_idx;
                        busy      <= 1'b1;
                        state     <= PASS;
                    end
                end
                PASS: begin
                    if (accept && sel_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_stream_packet_arbiter.md
Name: axi_stream_packet_arbiter

Overview:
- Shares one AXI-Stream master output between NUM_INPUTS AXI-Stream slave inputs.
- Arbitrates at packet granularity with round-robin fairness. A grant is held until the TLAST beat of the granted input is accepted.
- One registered output stage: every output signal is driven from a flop.
- Sits in front of any shared stream sink (DMA write port, egress MAC), so each upstream stream obeys the AXI-Stream handshake rules independently.

Parameters:
- NUM_INPUTS, 4, number of slave streams (2..16).
- byte_width, 4, TDATA width in bytes.
- user_width, 1, TUSER width (>=1).
- SEL_WIDTH, $clog2(NUM_INPUTS), width of source index and grant fields (derived; do not override).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- s_tvalid  input  NUM_INPUTS  per-input TVALID.
- s_tready  output  NUM_INPUTS  per-input TREADY.
- s_tdata  input  NUM_INPUTS*8*byte_width  flattened TDATA; input i at slice i.
- s_tkeep  input  NUM_INPUTS*byte_width  flattened TKEEP.
- s_tlast  input  NUM_INPUTS  per-input TLAST.
- s_tuser  input  NUM_INPUTS*user_width  flattened TUSER.
- m_tvalid  output  1  output TVALID.
- m_tready  input  1  output TREADY.
- m_tdata  output  8*byte_width  output TDATA.
- m_tkeep  output  byte_width  output TKEEP.
- m_tlast  output  1  output TLAST.
- m_tuser  output  user_width  output TUSER.
- m_tid  output  SEL_WIDTH  index of the source input for the current beat.
- busy  output  1  high while a grant is held (state PASS).
- grant_idx  output  SEL_WIDTH  currently or most recently granted input.

Behaviour:

Reset (asynchronous, while reset=1):
- state=IDLE; m_tvalid=0; m_tdata/m_tkeep/m_tlast/m_tuser/m_tid=0.
- s_tready=0; busy=0.
- last_grant=NUM_INPUTS-1, so input 0 wins first; grant_idx=NUM_INPUTS-1.

State IDLE:
- s_tready all 0.
- If any s_tvalid=1: pick the first requesting index searching last_grant+1, +2, … modulo NUM_INPUTS (wrap-around).
- Register that index into grant_idx and last_grant; go to PASS next cycle. busy=1 from that edge.

State PASS:
- s_tready[grant_idx] = !m_tvalid || m_tready. All other s_tready are 0.
- Input beat accepted when s_tvalid[g] && s_tready[g]:
  - Data, keep, last and user load the output register.
  - m_tid=g; m_tvalid=1 next cycle.
- If no accept and m_tready=1: m_tvalid clears next cycle.
- Accepted beat has s_tlast=1: go to IDLE next cycle; busy=0.
  - The output register still drains normally.
  - One bubble cycle minimum between packets.

Output stability:
- While m_tvalid && !m_tready, all m_* signals hold stable.
- m_tvalid never falls without a completed transfer, except on reset.

Latency:
- s_tvalid rising in IDLE (cycle 0) → grant at cycle 1 → s_tready at cycle 1 (output register empty) → m_tvalid at cycle 2.
- Steady-state throughput in PASS: 1 beat/cycle with m_tready=1.

Boundary conditions:
- Non-granted inputs deasserting s_tvalid have no effect.
- A granted input dropping s_tvalid mid-packet (protocol violation upstream) keeps the grant; no timeout.
- Single-beat packet (tlast on first beat): IDLE → PASS → IDLE. Each 1-beat packet costs 2 cycles.
- Only one input requesting: it regains the grant after its bubble.
- No requests: stay in IDLE; grant_idx holds its last value.
- Reset mid-packet: output beat discarded, m_tvalid=0 immediately; the arbiter restarts with input 0 priority.

Width rules:
- Slice i of a flattened bus is bits [(i+1)*W-1 : i*W].
- m_tid is zero-extended index; no arithmetic overflow is possible.

Properties for the bench:
- s_tready is at most one-hot.
- m_tid is constant within a packet.
- Beats from two inputs never interleave within a packet.

Test Plan:
- Reset, then s_tvalid=4'b0001, 3-beat packet (data 0xA0,0xA1,0xA2, tlast on 0xA2), m_tready=1 → m_tvalid first high 2 cycles after s_tvalid; beats out in order with m_tid=0; busy falls after the tlast beat is accepted.
- All four inputs continuously valid with 2-beat packets, m_tready=1 → m_tid sequence 0,0,1,1,2,2,3,3,0,0…; one idle bubble between packets.
- Inputs 1 and 3 valid, last_grant=1 → input 3 granted next; then input 1 (wrap from 3 to 0, skipping idle 0).
- Input 2 granted; hold m_tready=0 for 5 cycles mid-packet → m_* stable, s_tready[2]=0 once the register is full; all data delivered without loss after release.
- Assert reset mid-packet with m_tvalid=1 → m_tvalid and s_tready=0 immediately; after release, input 0 wins if 0 and 2 both request.
- Single-beat packets on input 1 only, m_tready=1 → one output beat every 2 cycles, all with m_tlast=1 and m_tid=1.
